// File: rtl/sliding_tile_pkg.sv
// Shared types for the sliding-tile puzzle board.
// Directions name where the blank moves; inverse() flips LEFT/RIGHT and UP/DOWN.
package sliding_tile_pkg;

  typedef enum logic [1:0] {
    LEFT  = 2'b00,
    RIGHT = 2'b01,
    UP    = 2'b10,
    DOWN  = 2'b11
  } dir_e;

  typedef enum logic {
    PLAY     = 1'b0,
    SCRAMBLE = 1'b1
  } state_e;

  function automatic dir_e inverse(dir_e d);
    return dir_e'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/sliding_tile_lfsr.sv
// 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
// Loads seed on reset and steps only while en is high.
module sliding_tile_lfsr (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] out
);

  logic fb;

  assign fb = out[15] ^ out[13] ^ out[12] ^ out[10];

  always_ff @(posedge clk) begin
    if (reset) begin
      out <= seed;
    end else if (en) begin
      out <= {out[14:0], fb};
    end
  end

endmodule

// File: rtl/sliding_tile_board.sv
// N x N sliding-tile puzzle with user moves and LFSR-driven scramble.
// User and scramble paths share one legality / target-index datapath.
module sliding_tile_board
  import sliding_tile_pkg::*;
#(
  parameter int          N     = 3,
  parameter int          TW    = $clog2(N*N),
  parameter int          CNT_W = 16,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               move_val,
  output logic               move_rdy,
  input  logic [1:0]         move_dir,
  input  logic               scr_start,
  input  logic [7:0]         scr_len,
  output logic               busy,
  output logic               move_ok,
  output logic               move_err,
  output logic [N*N*TW-1:0]  board,
  output logic [1:0]         blank_row,
  output logic [1:0]         blank_col,
  output logic               solved,
  output logic [CNT_W-1:0]   move_count
);

  localparam int CELLS = N * N;
  localparam int IW    = $clog2(CELLS);

  logic [TW-1:0] cells [CELLS];
  state_e        state;
  logic [7:0]    remaining;
  dir_e          prev_dir;
  logic          prev_vld;

  logic [15:0] lfsr_out;
  logic        lfsr_en;
  logic        lfsr_unused;

  dir_e          dir;
  logic          legal;
  logic          scr_take;
  logic          apply;
  logic [1:0]    tgt_row;
  logic [1:0]    tgt_col;
  logic [IW-1:0] tgt_idx;
  logic [IW-1:0] blank_idx;

  assign lfsr_en     = (state == SCRAMBLE);
  assign lfsr_unused = ^lfsr_out[15:2];
  assign move_rdy    = (state == PLAY);
  assign busy        = (state == SCRAMBLE);

  sliding_tile_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (lfsr_en),
    .seed  (SEED),
    .out   (lfsr_out)
  );

  always_comb begin
    dir     = (state == SCRAMBLE) ? dir_e'(lfsr_out[1:0])
                                  : dir_e'(move_dir);
    tgt_row = blank_row;
    tgt_col = blank_col;
    legal   = 1'b0;
    unique case (dir)
      LEFT: begin
        legal   = (blank_col != 2'd0);
        tgt_col = blank_col - 2'd1;
      end
      RIGHT: begin
        legal   = (int'(blank_col) < N - 1);
        tgt_col = blank_col + 2'd1;
      end
      UP: begin
        legal   = (blank_row != 2'd0);
        tgt_row = blank_row - 2'd1;
      end
      DOWN: begin
        legal   = (int'(blank_row) < N - 1);
        tgt_row = blank_row + 2'd1;
      end
    endcase
    tgt_idx   = IW'(int'(tgt_row) * N + int'(tgt_col));
    blank_idx = IW'(int'(blank_row) * N + int'(blank_col));
    // Scramble never undoes its own previous step.
    scr_take  = legal && !(prev_vld && dir == inverse(prev_dir));
    apply     = (state == PLAY) ? (move_val && legal)
                                : (remaining != 8'd0 && scr_take);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < CELLS; k++) begin
        cells[k] <= (k == CELLS - 1) ? '0 : TW'(k + 1);
      end
      blank_row  <= 2'(N - 1);
      blank_col  <= 2'(N - 1);
      move_count <= '0;
      move_ok    <= 1'b0;
      move_err   <= 1'b0;
      state      <= PLAY;
      remaining  <= 8'd0;
      prev_dir   <= LEFT;
      prev_vld   <= 1'b0;
    end else begin
      move_ok  <= 1'b0;
      move_err <= 1'b0;
      if (apply) begin
        cells[tgt_idx]   <= '0;
        cells[blank_idx] <= cells[tgt_idx];
        blank_row        <= tgt_row;
        blank_col        <= tgt_col;
      end
      unique case (state)
        PLAY: begin
          if (move_val) begin
            move_ok  <= legal;
            move_err <= !legal;
            if (legal && move_count != '1) begin
              move_count <= move_count + CNT_W'(1);
            end
          end else if (scr_start && scr_len != 8'd0) begin
            state     <= SCRAMBLE;
            remaining <= scr_len;
            prev_vld  <= 1'b0;
          end
        end
        SCRAMBLE: begin
          if (remaining == 8'd0) begin
            state      <= PLAY;
            move_count <= '0;
          end else if (scr_take) begin
            prev_dir  <= dir;
            prev_vld  <= 1'b1;
            remaining <= remaining - 8'd1;
          end
        end
      endcase
    end
  end

  always_comb begin
    solved = 1'b1;
    for (int k = 0; k < CELLS; k++) begin
      if (cells[k] != ((k == CELLS - 1) ? '0 : TW'(k + 1))) begin
        solved = 1'b0;
      end
    end
  end

  for (genvar k = 0; k < CELLS; k++) begin : g_board
    assign board[k*TW +: TW] = cells[k];
  end

endmodule

// File: tb/tb_sliding_tile_board.sv
// Scoreboard bench: array model predicts each move result, monitors compare.
// N=3 instance covers moves and scramble; N=4 instance (3-bit counter) covers corners and saturation.
module tb_sliding_tile_board;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        mv3, scr3, rdy3, busy3, ok3, err3, sol3;
  logic [1:0]  dir3, br3, bc3;
  logic [7:0]  len3;
  logic [35:0] brd3;
  logic [15:0] cnt3;

  logic        mv4, scr4, rdy4, busy4, ok4, err4, sol4;
  logic [1:0]  dir4, br4, bc4;
  logic [7:0]  len4;
  logic [63:0] brd4;
  logic [2:0]  cnt4;

  sliding_tile_board #(.N(3)) dut3 (
    .clk(clk), .reset(reset), .move_val(mv3), .move_rdy(rdy3),
    .move_dir(dir3), .scr_start(scr3), .scr_len(len3), .busy(busy3),
    .move_ok(ok3), .move_err(err3), .board(brd3), .blank_row(br3),
    .blank_col(bc3), .solved(sol3), .move_count(cnt3)
  );

  sliding_tile_board #(.N(4), .CNT_W(3)) dut4 (
    .clk(clk), .reset(reset), .move_val(mv4), .move_rdy(rdy4),
    .move_dir(dir4), .scr_start(scr4), .scr_len(len4), .busy(busy4),
    .move_ok(ok4), .move_err(err4), .board(brd4), .blank_row(br4),
    .blank_col(bc4), .solved(sol4), .move_count(cnt4)
  );

  typedef struct {
    bit          ok;
    logic [63:0] board;
    int          row;
    int          col;
    int          cnt;
    bit          solved;
  } exp_t;

  exp_t q3[$];
  exp_t q4[$];
  exp_t e3, e4;

  int checks   = 0;
  int failures = 0;

  int mcell [2][16];
  int mrow  [2];
  int mcol  [2];
  int mcnt  [2];
  int msize [2] = '{3, 4};
  int mmax  [2] = '{65535, 7};

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset(input int i);
    int n = msize[i];
    for (int k = 0; k < n * n; k++) begin
      mcell[i][k] = (k == n * n - 1) ? 0 : k + 1;
    end
    mrow[i] = n - 1;
    mcol[i] = n - 1;
    mcnt[i] = 0;
  endfunction

  function automatic logic [63:0] model_board(input int i);
    logic [63:0] b = '0;
    for (int k = 0; k < msize[i] * msize[i]; k++) begin
      b[k*4 +: 4] = 4'(mcell[i][k]);
    end
    return b;
  endfunction

  function automatic bit model_solved(input int i);
    int n = msize[i];
    for (int k = 0; k < n * n; k++) begin
      if (mcell[i][k] != ((k == n * n - 1) ? 0 : k + 1)) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_move(input int i, input int d,
                                     output exp_t e);
    int n = msize[i];
    int dr = 0, dc = 0, nr, nc;
    case (d)
      0: dc = -1;
      1: dc = 1;
      2: dr = -1;
      default: dr = 1;
    endcase
    nr = mrow[i] + dr;
    nc = mcol[i] + dc;
    if (nr >= 0 && nr < n && nc >= 0 && nc < n) begin
      mcell[i][mrow[i]*n + mcol[i]] = mcell[i][nr*n + nc];
      mcell[i][nr*n + nc] = 0;
      mrow[i] = nr;
      mcol[i] = nc;
      if (mcnt[i] < mmax[i]) mcnt[i]++;
      e.ok = 1'b1;
    end else begin
      e.ok = 1'b0;
    end
    e.board  = model_board(i);
    e.row    = mrow[i];
    e.col    = mcol[i];
    e.cnt    = mcnt[i];
    e.solved = model_solved(i);
  endfunction

  always @(negedge clk) begin
    if (!reset && (ok3 || err3)) begin
      if (q3.size() == 0) begin
        chk("unexpected_pulse3", {ok3, err3}, 0);
      end else begin
        e3 = q3.pop_front();
        chk("ok3", ok3, e3.ok);
        chk("err3", err3, !e3.ok);
        chk("board3", brd3, e3.board);
        chk("row3", br3, e3.row);
        chk("col3", bc3, e3.col);
        chk("count3", cnt3, e3.cnt);
        chk("solved3", sol3, e3.solved);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && (ok4 || err4)) begin
      if (q4.size() == 0) begin
        chk("unexpected_pulse4", {ok4, err4}, 0);
      end else begin
        e4 = q4.pop_front();
        chk("ok4", ok4, e4.ok);
        chk("err4", err4, !e4.ok);
        chk("board4", brd4, e4.board);
        chk("row4", br4, e4.row);
        chk("col4", bc4, e4.col);
        chk("count4", cnt4, e4.cnt);
        chk("solved4", sol4, e4.solved);
      end
    end
  end

  task automatic drain(input int i);
    for (int c = 0; c < 8; c++) begin
      if ((i == 0 ? q3.size() : q4.size()) == 0) break;
      @(negedge clk);
    end
    if ((i == 0 ? q3.size() : q4.size()) != 0) begin
      chk("response_timeout", i == 0 ? q3.size() : q4.size(), 0);
      if (i == 0) q3.delete(); else q4.delete();
    end
  endtask

  task automatic mv(input int i, input int d);
    exp_t e;
    model_move(i, d, e);
    @(posedge clk); #1;
    if (i == 0) begin
      q3.push_back(e); mv3 = 1'b1; dir3 = 2'(d);
    end else begin
      q4.push_back(e); mv4 = 1'b1; dir4 = 2'(d);
    end
    @(posedge clk); #1;
    mv3 = 1'b0;
    mv4 = 1'b0;
    drain(i);
  endtask

  task automatic run_scramble(input int len, output logic [63:0] fin);
    logic [63:0] pb, xb, nb;
    bit [15:0] seen;
    int pr, pc, nr, nc, dr, dc, pdr, pdc, moves;
    bit havep, done;
    pb = 64'(brd3); pr = br3; pc = bc3;
    havep = 0; moves = 0; done = 0; pdr = 0; pdc = 0;
    @(posedge clk); #1;
    scr3 = 1'b1; len3 = 8'(len);
    @(posedge clk); #1;
    scr3 = 1'b0;
    @(negedge clk);
    chk("scr_busy", busy3, 1);
    chk("scr_rdy", rdy3, 0);
    for (int c = 0; c < 400 && !done; c++) begin
      chk("scr_pulse", {ok3, err3}, 0);
      nb = 64'(brd3);
      if (nb !== pb) begin
        nr = br3; nc = bc3;
        dr = nr - pr; dc = nc - pc;
        chk("scr_step", (dr < 0 ? -dr : dr) + (dc < 0 ? -dc : dc), 1);
        xb = pb;
        xb[(nr*3 + nc)*4 +: 4] = 4'd0;
        xb[(pr*3 + pc)*4 +: 4] = pb[(nr*3 + nc)*4 +: 4];
        chk("scr_swap", nb, xb);
        if (havep) chk("scr_inverse", (dr == -pdr && dc == -pdc), 0);
        pdr = dr; pdc = dc; havep = 1; moves++;
        pb = nb; pr = nr; pc = nc;
      end
      if (!busy3) done = 1;
      else @(negedge clk);
    end
    chk("scr_timeout", done, 1);
    chk("scr_moves", moves, len);
    chk("scr_count", cnt3, 0);
    chk("scr_rdy_after", rdy3, 1);
    seen = '0;
    for (int k = 0; k < 9; k++) seen[brd3[k*4 +: 4]] = 1'b1;
    chk("scr_perm", seen, 16'h01ff);
    fin = 64'(brd3);
  endtask

  logic [63:0] fin1, fin2;
  exp_t ec;

  initial begin
    reset = 1'b1;
    mv3 = 0; scr3 = 0; dir3 = 0; len3 = 0;
    mv4 = 0; scr4 = 0; dir4 = 0; len4 = 0;
    model_reset(0);
    model_reset(1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_board3", brd3, model_board(0));
    chk("rst_blank3", {br3, bc3}, 4'b1010);
    chk("rst_count3", cnt3, 0);
    chk("rst_solved3", sol3, 1);
    chk("rst_flags3", {rdy3, busy3, ok3, err3}, 4'b1000);
    chk("rst_lfsr3", dut3.u_lfsr.out, 16'hACE1);
    chk("rst_board4", brd4, model_board(1));
    chk("rst_blank4", {br4, bc4}, 4'b1111);
    chk("rst_solved4", sol4, 1);

    mv(0, 1);
    mv(0, 0);
    mv(0, 1);

    for (int k = 0; k < 3; k++) mv(1, 2);
    for (int k = 0; k < 3; k++) mv(1, 0);
    mv(1, 2);
    for (int k = 0; k < 3; k++) mv(1, 1);

    for (int k = 0; k < 40; k++) mv(0, int'($urandom_range(0, 3)));
    for (int k = 0; k < 30; k++) mv(1, int'($urandom_range(0, 3)));

    model_move(0, 0, ec);
    @(posedge clk); #1;
    q3.push_back(ec);
    mv3 = 1'b1; dir3 = 2'd0; scr3 = 1'b1; len3 = 8'd20;
    @(posedge clk); #1;
    mv3 = 1'b0; scr3 = 1'b0;
    drain(0);
    @(negedge clk);
    chk("both_busy", busy3, 0);
    @(posedge clk); #1;
    scr3 = 1'b1; len3 = 8'd0;
    @(posedge clk); #1;
    scr3 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("len0_busy", busy3, 0);
    end

    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    model_reset(0);
    model_reset(1);

    run_scramble(20, fin1);

    @(posedge clk); #1;
    scr3 = 1'b1; len3 = 8'd20;
    @(posedge clk); #1;
    scr3 = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", busy3, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_board", brd3, model_board(0));
    chk("mid_solved", sol3, 1);
    chk("mid_busy_clr", busy3, 0);
    chk("mid_blank", {br3, bc3}, 4'b1010);
    chk("mid_lfsr", dut3.u_lfsr.out, 16'hACE1);

    run_scramble(20, fin2);
    chk("scr_repro", fin2, fin1);

    repeat (3) @(negedge clk);
    if (q3.size() != 0) chk("leftover3", q3.size(), 0);
    if (q4.size() != 0) chk("leftover4", q4.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sliding_tile_board.md
SLIDING_TILE_BOARD -- requirements
Module: sliding_tile_board

Interface
REQ-001 SHALL have parameter N, default 3, meaning board edge length; legal range 2..4.
REQ-002 SHALL have parameter TW, default $clog2(N*N), meaning tile-value width.
REQ-003 SHALL have parameter CNT_W, default 16, meaning move-counter width.
REQ-004 SHALL have parameter SEED, default 16'hACE1, meaning the LFSR value loaded at reset; a zero SEED is illegal.
REQ-005 SHALL have ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- move_val  input  1  move request valid
- move_rdy  output  1  block can accept a move
- move_dir  input  2  direction the blank moves: 00 LEFT, 01 RIGHT, 10 UP, 11 DOWN
- scr_start  input  1  start scramble (single-cycle sample)
- scr_len  input  8  number of legal scramble moves
- busy  output  1  scramble in progress
- move_ok  output  1  one-cycle pulse, legal user move applied
- move_err  output  1  one-cycle pulse, illegal user move rejected
- board  output  N*N*TW  cell k=row*N+col at bits [k*TW +: TW]; value 0 = blank
- blank_row  output  2  blank row, 0 = top
- blank_col  output  2  blank column, 0 = left
- solved  output  1  board in goal configuration
- move_count  output  CNT_W  legal user moves since reset or scramble end

Function
REQ-006 SHALL implement FSM states PLAY and SCRAMBLE; reset enters PLAY.
REQ-007 In PLAY, move_rdy SHALL be 1; in SCRAMBLE, move_rdy SHALL be 0.
REQ-008 A move SHALL be accepted on a cycle with move_val && move_rdy.
REQ-009 A move SHALL be legal iff the target cell is inside the board:
- LEFT: col>0
- RIGHT: col<N-1
- UP: row>0
- DOWN: row<N-1
REQ-010 For a legal accepted move, on the next edge the block SHALL:
- swap the blank and the target tile;
- update blank_row/blank_col;
- assert move_ok for exactly one cycle, coincident with the updated board.
REQ-011 An illegal accepted move SHALL leave board and blank position unchanged and assert move_err one cycle after acceptance.
REQ-012 move_count SHALL increment by 1 per move_ok and saturate at all-ones; illegal moves SHALL NOT count.
REQ-013 solved SHALL be combinational from the registered board: 1 iff cell k holds k+1 for k<N*N-1 and the last cell holds 0.
REQ-014 If scr_start is sampled in PLAY with scr_len != 0, the FSM SHALL enter SCRAMBLE next cycle, and busy SHALL be 1.
- scr_start with scr_len==0 SHALL be ignored.
- scr_start in SCRAMBLE SHALL be ignored.
REQ-015 If move_val and scr_start are both high in PLAY, the user move SHALL be accepted and the scramble request SHALL be ignored.
REQ-016 In SCRAMBLE, each cycle the block SHALL take LFSR bits [1:0] as a candidate direction.
- If the candidate is legal and is not the inverse of the previous scramble move, the block SHALL apply it and decrement the remaining count.
- Otherwise no board change occurs.
- The LFSR SHALL advance every SCRAMBLE cycle.
REQ-017 Scramble moves SHALL NOT pulse move_ok or move_err and SHALL NOT increment move_count.
REQ-018 When the remaining count reaches 0, the FSM SHALL return to PLAY on the next edge, busy SHALL fall, and move_count SHALL clear to 0.
REQ-019 The LFSR SHALL be 16-bit maximal length with polynomial x^16+x^14+x^13+x^11+1, and SHALL free-run only in SCRAMBLE.
REQ-020 The board SHALL always remain a permutation of 0..N*N-1.

Reset
REQ-021 Reset SHALL be synchronous and active-high, and SHALL take priority over all other inputs, including mid-scramble.
REQ-022 On reset the block SHALL set:
- board: cell k = k+1 for k<N*N-1, last cell = 0;
- blank_row = blank_col = N-1;
- move_count = 0;
- move_ok = move_err = 0;
- busy = 0;
- LFSR = SEED;
- state = PLAY.

Structure
REQ-023 Package sliding_tile_pkg SHALL hold the direction enum (LEFT/RIGHT/UP/DOWN encodings) and the FSM state enum.
REQ-024 The LFSR SHALL be a sub-module, sliding_tile_lfsr, with ports clk, reset, en, seed, and out[15:0].
REQ-025 The legality check and the target-cell index computation SHALL be shared between the user path and the scramble path.

Verification
REQ-026 N=3, reset then move RIGHT -> move_err pulse, board unchanged, move_count=0, solved=1.
REQ-027 N=3, from reset, move LEFT -> cell7=0, cell8=8, blank=(2,1), move_ok, move_count=1, solved=0; then move RIGHT -> solved=1, move_count=2.
REQ-028 N=3, scr_start with scr_len=20 -> busy high and move_rdy=0 until exactly 20 legal moves are applied; board remains a permutation; afterwards move_count=0 and no move_ok/err pulses occurred.
REQ-029 N=4, from reset, UP x3 then LEFT x3 -> blank=(0,0), move_count=6; a further UP -> move_err.
REQ-030 Reset asserted mid-scramble -> next cycle board is solved, busy=0, LFSR=SEED; a repeat scramble with the same scr_len reproduces the identical board.
REQ-031 move_val held high with scr_start on the same cycle -> move accepted, no scramble entered; then scr_start with scr_len=0 -> busy stays 0.
